// File: rtl/sram_mbist_pkg.sv
// Shared types and March C- element tables for the SRAM MBIST controller.
// Element order: E0 A(w0), E1 A(r0,w1), E2 A(r1,w0), E3 D(r0,w1), E4 D(r1,w0), E5 A(r0).
package sram_mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int                  NUM_ELEM      = 6;
    localparam logic [2:0]          LAST_ELEM     = 3'd5;
    // One bit per element, bit index = element number.
    localparam logic [NUM_ELEM-1:0] ELEM_DESC     = 6'b011000;
    localparam logic [NUM_ELEM-1:0] ELEM_TWO_OP   = 6'b011110;
    localparam logic [NUM_ELEM-1:0] ELEM_RD_POL   = 6'b010100;
    localparam logic [NUM_ELEM-1:0] ELEM_WR_POL   = 6'b001010;
    localparam logic [NUM_ELEM-1:0] ELEM_WR_FIRST = 6'b000001;

    function automatic logic elem_bit(input logic [NUM_ELEM-1:0] tbl, input logic [2:0] e);
        logic b;
        b = 1'b0;
        if (e < 3'(NUM_ELEM)) b = tbl[e];
        else                  b = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/sram_mbist_cmp.sv
// Read-compare pipeline: captures each issued read, compares the returned
// data one cycle later, and keeps sticky first-fail info plus a saturating count.
module sram_mbist_cmp
    import sram_mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_rd_valid,
    input  logic [DATA_W-1:0] i_expected,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_elem,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_fail,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [2:0]        o_fail_elem,
    output logic [CNT_W-1:0]  o_fail_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              r_valid;
    logic [DATA_W-1:0] r_exp;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_elem;
    logic              w_miss;

    assign w_miss = r_valid && (i_rdata != r_exp);

    // Stage register: remembers what the read in flight must return.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_valid <= 1'b0;
            r_exp   <= {DATA_W{1'b0}};
            r_addr  <= {ADDR_W{1'b0}};
            r_elem  <= 3'd0;
        end else begin
            r_valid <= i_rd_valid;
            if (i_rd_valid) begin
                r_exp  <= i_expected;
                r_addr <= i_addr;
                r_elem <= i_elem;
            end
        end
    end

    // Result registers: first miscompare is latched, later ones only counted.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            o_fail       <= 1'b0;
            o_fail_addr  <= {ADDR_W{1'b0}};
            o_fail_elem  <= 3'd0;
            o_fail_count <= {CNT_W{1'b0}};
        end else if (w_miss) begin
            if (!o_fail) begin
                o_fail      <= 1'b1;
                o_fail_addr <= r_addr;
                o_fail_elem <= r_elem;
            end
            if (o_fail_count != CNT_MAX) o_fail_count <= o_fail_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/sram_mbist_ctrl.sv
// March C- MBIST initiator for an RW0-style single-port SRAM: FSM, element/op/
// address sequencer and registered memory-port drive; compares live in sram_mbist_cmp.
module sram_mbist_ctrl
    import sram_mbist_pkg::*;
#(
    parameter int                ADDR_W = 6,
    parameter int                DATA_W = 32,
    parameter int                MASK_W = 4,
    parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}},
    parameter int                CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              bist_active,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_elem, r_mem_elem;
    logic              r_op, r_seq_end;
    logic [ADDR_W-1:0] r_addr;
    logic              w_launch, w_issue, w_desc, w_two, w_is_wr, w_pol, w_addr_end, w_nxt_desc;
    logic [DATA_W-1:0] w_pat;

    // Next-state logic plus launch/issue strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_launch    = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (r_seq_end) w_state_nxt = ST_DRAIN;
                else           w_issue     = 1'b1;
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Decode of the current op from the element tables.
    always_comb begin
        w_desc     = elem_bit(ELEM_DESC, r_elem);
        w_two      = elem_bit(ELEM_TWO_OP, r_elem);
        w_is_wr    = r_op | elem_bit(ELEM_WR_FIRST, r_elem);
        w_nxt_desc = elem_bit(ELEM_DESC, r_elem + 3'd1);
        if (w_is_wr) w_pol = elem_bit(ELEM_WR_POL, r_elem);
        else         w_pol = elem_bit(ELEM_RD_POL, r_elem);
        if (w_pol) w_pat = ~BG;
        else       w_pat = BG;
        if (w_desc) w_addr_end = (r_addr == ADDR_ZERO);
        else        w_addr_end = (r_addr == ADDR_MAX);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Sequencer: read then write at one address, then step; wrap ends the element.
    always_ff @(posedge clock) begin
        if (reset || w_launch) begin
            r_elem    <= 3'd0;
            r_op      <= 1'b0;
            r_addr    <= ADDR_ZERO;
            r_seq_end <= 1'b0;
        end else if (w_issue) begin
            if (w_two && !r_op) begin
                r_op <= 1'b1;
            end else begin
                r_op <= 1'b0;
                if (w_addr_end) begin
                    if (r_elem == LAST_ELEM) begin
                        r_seq_end <= 1'b1;
                    end else begin
                        r_elem <= r_elem + 3'd1;
                        r_addr <= w_nxt_desc ? ADDR_MAX : ADDR_ZERO;
                    end
                end else if (w_desc) begin
                    r_addr <= r_addr - {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Registered status and memory-port outputs; address/data hold when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            done        <= 1'b0;
            bist_active <= 1'b0;
            mem_en      <= 1'b0;
            mem_wmode   <= 1'b0;
            mem_wmask   <= {MASK_W{1'b0}};
            mem_addr    <= ADDR_ZERO;
            mem_wdata   <= {DATA_W{1'b0}};
            r_mem_elem  <= 3'd0;
        end else begin
            done        <= (w_state_nxt == ST_DONE);
            bist_active <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            if (w_issue) begin
                mem_en     <= 1'b1;
                mem_wmode  <= w_is_wr;
                mem_wmask  <= w_is_wr ? {MASK_W{1'b1}} : {MASK_W{1'b0}};
                mem_addr   <= r_addr;
                mem_wdata  <= w_pat;
                r_mem_elem <= r_elem;
            end else begin
                mem_en    <= 1'b0;
                mem_wmode <= 1'b0;
                mem_wmask <= {MASK_W{1'b0}};
            end
        end
    end

    sram_mbist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_launch),
        .i_rd_valid   (mem_en & ~mem_wmode),
        .i_expected   (mem_wdata),
        .i_addr       (mem_addr),
        .i_elem       (r_mem_elem),
        .i_rdata      (mem_rdata),
        .o_fail       (fail),
        .o_fail_addr  (fail_addr),
        .o_fail_elem  (fail_elem),
        .o_fail_count (fail_count)
    );

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// Directed bench for sram_mbist_ctrl against a 64x32 RW0 model with
// selectable read-side fault injection.
module tb_sram_mbist_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        bist_active, done, fail, mem_en, mem_wmode;
    logic [5:0]  fail_addr, mem_addr;
    logic [2:0]  fail_elem;
    logic [7:0]  fail_count;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [0:63];
    int          acc_cnt = 0;
    int          fault_mode = 0;
    int          corrupt_at = -1;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clock = ~clock;

    sram_mbist_ctrl dut (
        .clock(clock), .reset(reset), .start(start),
        .bist_active(bist_active), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_count(fail_count),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [31:0] read_fault(input logic [31:0] w, input logic [5:0] a, input int idx);
        logic [31:0] r;
        r = w;
        if (fault_mode == 1 && a == 6'h12) r = r | 32'h0000_0020;
        if (fault_mode == 2) r = r & 32'hFFFF_FFFE;
        if (fault_mode == 3 && idx == corrupt_at) r = r ^ 32'h0000_0001;
        return r;
    endfunction

    // RW0 macro model: 1-cycle read latency, byte write mask, access counter.
    always @(posedge clock) begin
        if (mem_en) begin
            acc_cnt <= acc_cnt + 1;
            if (mem_wmode) mem[mem_addr] <= (mem[mem_addr] & ~bmask(mem_wmask)) | (mem_wdata & bmask(mem_wmask));
            else           mem_rdata <= read_fault(mem[mem_addr], mem_addr, acc_cnt);
        end
    end

    task automatic run_to_done(input bit hold, output int cycles, output int accesses);
        int base;
        base = acc_cnt;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        cycles = 0;
        while (cycles < 3000 && !done) begin
            @(posedge clock); #1;
            cycles++;
        end
        accesses = acc_cnt - base;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if ({bist_active, done, fail, fail_addr, fail_elem, fail_count, mem_en, mem_wmode, mem_wmask, mem_addr, mem_wdata} !== 64'h0)
            $display("FAIL reset_outputs: outputs not all zero (done=%0b act=%0b en=%0b)", done, bist_active, mem_en);
        else n_pass++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_march_pass();
        int cyc, base;
        fault_mode = 0;
        base = acc_cnt;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        n_total++;
        if (bist_active !== 1'b1 || mem_en !== 1'b0) $display("FAIL pass_launch: act=%0b en=%0b want 1/0", bist_active, mem_en);
        else n_pass++;
        cyc = 0;
        while (cyc < 3000 && !done) begin
            @(posedge clock); #1;
            cyc++;
            case (cyc)
                1: begin
                    n_total++;
                    if ({mem_en, mem_wmode, mem_wmask, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'hF, 6'h00, 32'h0})
                        $display("FAIL first_access: en=%0b wm=%0b mask=%h a=%h d=%h", mem_en, mem_wmode, mem_wmask, mem_addr, mem_wdata);
                    else n_pass++;
                end
                65: begin
                    n_total++;
                    if ({mem_en, mem_wmode, mem_addr, mem_wdata} !== {1'b1, 1'b0, 6'h00, 32'h0})
                        $display("FAIL e1_read: wm=%0b a=%h d=%h want 0/00/0", mem_wmode, mem_addr, mem_wdata);
                    else n_pass++;
                end
                66: begin
                    n_total++;
                    if ({mem_en, mem_wmode, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'h00, 32'hFFFF_FFFF})
                        $display("FAIL e1_write: wm=%0b a=%h d=%h want 1/00/ffffffff", mem_wmode, mem_addr, mem_wdata);
                    else n_pass++;
                end
                321: begin
                    n_total++;
                    if ({mem_en, mem_wmode, mem_addr, mem_wdata} !== {1'b1, 1'b0, 6'h3F, 32'h0})
                        $display("FAIL e3_start: wm=%0b a=%h d=%h want 0/3f/0", mem_wmode, mem_addr, mem_wdata);
                    else n_pass++;
                end
                640: begin
                    n_total++;
                    if ({mem_en, mem_wmode, mem_addr, done} !== {1'b1, 1'b0, 6'h3F, 1'b0})
                        $display("FAIL last_access: en=%0b wm=%0b a=%h done=%0b", mem_en, mem_wmode, mem_addr, done);
                    else n_pass++;
                end
                641: begin
                    n_total++;
                    if ({mem_en, bist_active, done} !== 3'b010)
                        $display("FAIL drain_cycle: en=%0b act=%0b done=%0b want 0/1/0", mem_en, bist_active, done);
                    else n_pass++;
                end
                default: ;
            endcase
        end
        n_total++;
        if (cyc !== 642) $display("FAIL pass_latency: done after %0d cycles, want 642", cyc);
        else n_pass++;
        n_total++;
        if (acc_cnt - base !== 640) $display("FAIL pass_accesses: %0d, want 640", acc_cnt - base);
        else n_pass++;
        n_total++;
        if ({fail, fail_count, fail_addr, fail_elem, bist_active} !== 19'h0)
            $display("FAIL pass_result: fail=%0b cnt=%0d act=%0b want 0/0/0", fail, fail_count, bist_active);
        else n_pass++;
    endtask

    task automatic test_fault(input int mode, input logic [5:0] exp_addr, input logic [2:0] exp_elem, input logic [7:0] exp_cnt);
        int cyc, acc;
        fault_mode = mode;
        corrupt_at = acc_cnt + 639;
        run_to_done(1'b0, cyc, acc);
        n_total++;
        if (cyc !== 642 || acc !== 640) $display("FAIL fault%0d_timing: cycles=%0d acc=%0d want 642/640", mode, cyc, acc);
        else n_pass++;
        n_total++;
        if ({fail, fail_elem, fail_addr, fail_count} !== {1'b1, exp_elem, exp_addr, exp_cnt})
            $display("FAIL fault%0d_result: fail=%0b elem=%0d addr=%h cnt=%0d want 1/%0d/%h/%0d",
                     mode, fail, fail_elem, fail_addr, fail_count, exp_elem, exp_addr, exp_cnt);
        else n_pass++;
        fault_mode = 0;
    endtask

    task automatic test_reset_mid_run();
        int cyc, acc;
        fault_mode = 0;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        n_total++;
        if (mem_en !== 1'b1 || bist_active !== 1'b1) $display("FAIL midrun_busy: en=%0b act=%0b want 1/1", mem_en, bist_active);
        else n_pass++;
        reset = 1'b1;
        @(posedge clock); #1;
        n_total++;
        if ({bist_active, done, fail, fail_addr, fail_elem, fail_count, mem_en, mem_wmode, mem_wmask, mem_addr, mem_wdata} !== 64'h0)
            $display("FAIL midrun_reset: en=%0b act=%0b addr=%h d=%h want all 0", mem_en, bist_active, mem_addr, mem_wdata);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        run_to_done(1'b0, cyc, acc);
        n_total++;
        if (cyc !== 642 || acc !== 640 || fail !== 1'b0)
            $display("FAIL after_reset_run: cycles=%0d acc=%0d fail=%0b want 642/640/0", cyc, acc, fail);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, acc, base;
        fault_mode = 2;
        run_to_done(1'b1, cyc, acc);
        n_total++;
        if (cyc !== 642 || acc !== 640 || bist_active !== 1'b0 || fail !== 1'b1 || fail_count !== 8'd128)
            $display("FAIL held_first_run: cycles=%0d acc=%0d act=%0b fail=%0b cnt=%0d", cyc, acc, bist_active, fail, fail_count);
        else n_pass++;
        @(posedge clock); #1;
        fault_mode = 0;
        base = acc_cnt;
        n_total++;
        if ({done, bist_active, fail, fail_count, fail_elem, fail_addr} !== {1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 6'd0})
            $display("FAIL restart_clear: done=%0b act=%0b fail=%0b cnt=%0d want 0/1/0/0", done, bist_active, fail, fail_count);
        else n_pass++;
        cyc = 0;
        while (cyc < 3000 && !done) begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 10)  start = 1'b0;
            if (cyc == 300) start = 1'b1;
            if (cyc == 301) start = 1'b0;
        end
        n_total++;
        if (cyc !== 642 || acc_cnt - base !== 640 || fail !== 1'b0)
            $display("FAIL start_ignored: cycles=%0d acc=%0d fail=%0b want 642/640/0", cyc, acc_cnt - base, fail);
        else n_pass++;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if (done !== 1'b1 || bist_active !== 1'b0) $display("FAIL done_hold: done=%0b act=%0b want 1/0", done, bist_active);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_march_pass();
        test_fault(1, 6'h12, 3'd1, 8'd3);
        test_fault(2, 6'h00, 3'd2, 8'd128);
        test_fault(3, 6'h3F, 3'd5, 8'd1);
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_mbist_ctrl.md
Name: sram_mbist_ctrl

Overview:
- March C- memory built-in self-test (MBIST) initiator for the single-port SRAM macro interface (RW0_addr/en/wmode/wmask/wdata/rdata, 1-cycle read latency).
- It generates every access, compares read data one cycle later, and reports pass/fail with first-failure capture.
- It sits beside each RW0-style macro wrapper. A separate mux in the parent selects between the functional port and the BIST port using bist_active.

Parameters:
- ADDR_W, 6: address width; depth = 2^ADDR_W.
- DATA_W, 32: data width.
- MASK_W, 4: write-mask width; driven all-ones on every BIST write.
- BG, 32'h0000_0000: data background for the "0" pattern; "1" pattern = ~BG.
- CNT_W, 8: fail_count width (saturating).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled only in IDLE or DONE.
- bist_active  out  1  high while accesses or the final compare are pending (RUN, DRAIN).
- done  out  1  high in DONE until the next start or reset.
- fail  out  1  sticky; at least one read miscompare in this run.
- fail_addr  out  ADDR_W  address of the first miscompare.
- fail_elem  out  3  March element index (0-5) of the first miscompare.
- fail_count  out  CNT_W  count of miscompared reads; saturates at all-ones.
- mem_addr  out  ADDR_W  to RW0_addr.
- mem_en  out  1  to RW0_en.
- mem_wmode  out  1  to RW0_wmode; 1 = write.
- mem_wmask  out  MASK_W  to RW0_wmask.
- mem_wdata  out  DATA_W  to RW0_wdata.
- mem_rdata  in  DATA_W  from RW0_rdata; valid the cycle after a read access.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0, and the state is IDLE.
- Reset mid-run: the next cycle has mem_en=0, bist_active=0, and all results cleared; no partial run resumes.
- Element sequence (A = ascending address 0 to 2^ADDR_W-1, D = descending):
  - E0 A(w0)
  - E1 A(r0,w1)
  - E2 A(r1,w0)
  - E3 D(r0,w1)
  - E4 D(r1,w0)
  - E5 A(r0)
  - "0" = BG, "1" = ~BG.
- Two-op elements issue the read, then the write, at the same address on consecutive cycles, then advance the address. There are no idle cycles between ops or between elements.
- Access count = 10*2^ADDR_W (640 at default).
- FSM transitions:
  - IDLE: start=1 → RUN, clearing fail, fail_addr, fail_elem and fail_count. The first access (E0 w0 at addr 0) is driven in the next cycle.
  - RUN: mem_en=1 every cycle. After the E5 read of the last address → DRAIN.
  - DRAIN: one cycle, mem_en=0, final compare performed → DONE.
  - DONE: done=1. start=1 → RUN (restart, results cleared).
- start is ignored in RUN and DRAIN.
- Write accesses: mem_wmode=1, mem_wmask all-ones, mem_wdata = pattern.
- Read accesses: mem_wmode=0, and mem_wdata is held at the pattern value (don't-care to the macro).
- Compare stage:
  - A read issued in cycle N registers {expected, addr, elem, valid}.
  - In cycle N+1, mem_rdata is compared with expected; a mismatch updates the results in N+2.
  - The compare holds even though a write to the same address occupies cycle N+1.
- First miscompare: fail=1, and fail_addr and fail_elem are loaded. Later miscompares only increment fail_count (saturating). The test continues to completion.
- Address counter: ADDR_W bits. Wrap at the last address marks element end. For the descending direction, the counter loads 2^ADDR_W-1 at element start and ends at 0.
- bist_active = state in {RUN, DRAIN}; it falls in the same cycle done rises.

Decomposition:
- Package sram_mbist_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - NUM_ELEM=6
  - per-element constant tables: direction, op count, read polarity, write polarity
- Sub-module sram_mbist_cmp: compare pipeline register plus sticky first-fail capture and saturating counter.
- The top level holds the FSM, the element/op/address sequencer and the output registers.

Test Plan:
1. Fault-free behavioural 64x32 RW0 model, 1-cycle start pulse → exactly 640 mem_en cycles; done rises 642 cycles after the start edge; fail=0, fail_count=0.
2. Stuck-at-1 on bit 5 at addr 0x12 → fail=1, fail_elem=1, fail_addr=0x12, fail_count=3 (E1, E3, E5 r0 reads).
3. Stuck-at-0 on bit 0 at every address → fail_elem=2, fail_addr=0x00, fail_count=128 (E2 and E4 r1 reads).
4. Corrupt rdata only on the E5 read of addr 0x3F → fail_elem=5, fail_addr=0x3F, fail_count=1; corruption is caught in DRAIN.
5. Assert reset at the 100th access cycle → the next cycle has all outputs 0 and mem_en=0. A new start then gives a clean 640-access pass.
6. start held high throughout → a single run, no restart while busy; DONE is immediately followed by RUN with results cleared. A start pulse in RUN is ignored (access count stays 640).
